// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit: Status/Cause/EPC/Count/Compare registers,
// Count/Compare timer, interrupt sampling and masking, and exception/ERET
// sequencing with a one-cycle registered PC redirect to fetch.
module cp0_exc_unit #(
  parameter int          NUM_HW_INT = 5,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  c0_valid,
  input  logic [2:0]            c0_op,
  input  logic [4:0]            c0_rd_id,
  input  logic [31:0]           mtc0_data,
  output logic [31:0]           mfc0_data_o,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic                  exc_req,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           int_pc,
  output logic                  irq_take_o,
  output logic                  redirect_valid_o,
  output logic [31:0]           redirect_pc_o,
  output logic                  timer_int_o
);

  localparam logic [2:0] OP_MFC0 = 3'd0;
  localparam logic [2:0] OP_MTC0 = 3'd1;
  localparam logic [2:0] OP_ERET = 3'd2;
  localparam logic [2:0] OP_DI   = 3'd3;
  localparam logic [2:0] OP_EI   = 3'd4;

  localparam logic [4:0] ID_COUNT   = 5'd9;
  localparam logic [4:0] ID_COMPARE = 5'd11;
  localparam logic [4:0] ID_STATUS  = 5'd12;
  localparam logic [4:0] ID_CAUSE   = 5'd13;
  localparam logic [4:0] ID_EPC     = 5'd14;

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [31:0] count_r, compare_r, epc_r;
  logic [7:0]  im_r;
  logic        exl_r, ie_r;
  logic        bd_r, ti_r;
  logic [1:0]  sw_ip_r;
  logic [4:0]  exc_code_r;
  logic [PW-1:0] presc_r;
  logic        redirect_valid_r;
  logic [31:0] redirect_pc_r;

  logic [7:0]  ip;
  logic [31:0] status_val, cause_val, rd_val;
  logic        int_pending, take_exc, do_eret, mtc0_w;
  logic        wr_count, wr_compare, presc_wrap;
  logic [31:0] count_inc;

  // Pending-interrupt vector: software bits, live hardware lines, timer on IP7.
  always_comb begin
    ip = 8'h00;
    ip[1:0] = sw_ip_r;
    for (int k = 0; k < NUM_HW_INT; k++) begin
      ip[2+k] = hw_int_i[k];
    end
    if (NUM_HW_INT == 5) begin
      ip[7] = ti_r | hw_int_i[NUM_HW_INT-1];
    end else begin
      ip[7] = ti_r;
    end
  end

  assign status_val  = {16'h0000, im_r, 6'b000000, exl_r, ie_r};
  assign cause_val   = {bd_r, ti_r, 14'h0000, ip, 1'b0, exc_code_r, 2'b00};
  assign int_pending = ie_r & ~exl_r & (|(ip & im_r));
  assign take_exc    = exc_req | int_pending;
  assign do_eret     = ~take_exc & c0_valid & (c0_op == OP_ERET);
  assign mtc0_w      = ~take_exc & c0_valid & (c0_op == OP_MTC0);
  assign wr_count    = mtc0_w & (c0_rd_id == ID_COUNT);
  assign wr_compare  = mtc0_w & (c0_rd_id == ID_COMPARE);
  assign presc_wrap  = (presc_r == PW'(COUNT_DIV - 1));
  assign count_inc   = count_r + 32'd1;

  assign irq_take_o       = int_pending & ~exc_req;
  assign redirect_valid_o = redirect_valid_r;
  assign redirect_pc_o    = redirect_pc_r;
  assign timer_int_o      = ti_r;

  // Read mux: current (pre-write) register value; DI always returns Status.
  always_comb begin
    rd_val = 32'h0000_0000;
    case (c0_rd_id)
      ID_COUNT:   rd_val = count_r;
      ID_COMPARE: rd_val = compare_r;
      ID_STATUS:  rd_val = status_val;
      ID_CAUSE:   rd_val = cause_val;
      ID_EPC:     rd_val = epc_r;
      default:    rd_val = 32'h0000_0000;
    endcase
    if (c0_valid && (c0_op == OP_DI)) begin
      mfc0_data_o = status_val;
    end else begin
      mfc0_data_o = rd_val;
    end
  end

  // Timer: prescaler, Count, Compare and the TI flag; software writes win.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r   <= '0;
      count_r   <= 32'h0000_0000;
      compare_r <= 32'h0000_0000;
      ti_r      <= 1'b0;
    end else begin
      if (wr_count) begin
        presc_r <= '0;
        count_r <= mtc0_data;
      end else if (presc_wrap) begin
        presc_r <= '0;
        count_r <= count_inc;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      if (wr_compare) begin
        compare_r <= mtc0_data;
        ti_r      <= 1'b0;
      end else if (presc_wrap && !wr_count && (count_inc == compare_r)) begin
        ti_r <= 1'b1;
      end
    end
  end

  // Status/Cause/EPC sequencing: exception > interrupt > ERET > DI/EI/MTC0.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      im_r       <= 8'h00;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      sw_ip_r    <= 2'b00;
      exc_code_r <= 5'd0;
      epc_r      <= 32'h0000_0000;
    end else if (take_exc) begin
      exc_code_r <= exc_req ? exc_code : 5'd0;
      exl_r      <= 1'b1;
      if (!exl_r) begin
        if (exc_req) begin
          epc_r <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          bd_r  <= exc_bd;
        end else begin
          epc_r <= int_pc;
          bd_r  <= 1'b0;
        end
      end
    end else if (do_eret) begin
      exl_r <= 1'b0;
    end else if (c0_valid) begin
      case (c0_op)
        OP_DI: ie_r <= 1'b0;
        OP_EI: ie_r <= 1'b1;
        OP_MTC0: begin
          if (c0_rd_id == ID_STATUS) begin
            im_r  <= mtc0_data[15:8];
            exl_r <= mtc0_data[1];
            ie_r  <= mtc0_data[0];
          end else if (c0_rd_id == ID_CAUSE) begin
            sw_ip_r <= mtc0_data[9:8];
          end
        end
        default: ;
      endcase
    end
  end

  // Redirect: one-cycle pulse to the exception vector or to EPC on ERET.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0000_0000;
    end else if (take_exc) begin
      redirect_valid_r <= 1'b1;
      redirect_pc_r    <= EXC_VECTOR;
    end else if (do_eret) begin
      redirect_valid_r <= 1'b1;
      redirect_pc_r    <= epc_r;
    end else begin
      redirect_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: stimulus pushes expected redirects,
// read data and level probes; a negedge monitor pops and compares.
module tb_cp0_exc_unit;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c0_valid = 1'b0;
  logic [2:0]  c0_op = 3'd7;
  logic [4:0]  c0_rd_id = 5'd0;
  logic [31:0] mtc0_data = 32'd0;
  logic [31:0] mfc0_data_o;
  logic [4:0]  hw_int_i = 5'd0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [31:0] exc_pc = 32'd0;
  logic        exc_bd = 1'b0;
  logic [31:0] int_pc = 32'h0000_1234;
  logic        irq_take_o, redirect_valid_o, timer_int_o;
  logic [31:0] redirect_pc_o;

  cp0_exc_unit #(.NUM_HW_INT(5), .COUNT_DIV(2), .EXC_VECTOR(32'h0000_0180)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .c0_valid(c0_valid), .c0_op(c0_op),
    .c0_rd_id(c0_rd_id), .mtc0_data(mtc0_data), .mfc0_data_o(mfc0_data_o),
    .hw_int_i(hw_int_i), .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .int_pc(int_pc), .irq_take_o(irq_take_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .timer_int_o(timer_int_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          kind;   // 0 timer_int, 1 irq_take, 2 redirect_valid, 3 redirect_pc, 4 queues_empty
    logic [31:0] exp;
  } probe_t;

  logic [31:0] redir_q[$];
  logic [31:0] rd_q[$];
  probe_t      pq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  probe_t      mon_p;
  logic [31:0] mon_act, mon_exp;
  string       mon_nm;

  // Monitor: all comparisons happen here, away from the active clock edge.
  always @(negedge sys_clk) begin
    while (pq.size() > 0) begin
      mon_p = pq.pop_front();
      case (mon_p.kind)
        0: begin mon_nm = "timer_int"; mon_act = {31'd0, timer_int_o}; end
        1: begin mon_nm = "irq_take"; mon_act = {31'd0, irq_take_o}; end
        2: begin mon_nm = "redirect_valid"; mon_act = {31'd0, redirect_valid_o}; end
        3: begin mon_nm = "redirect_pc"; mon_act = redirect_pc_o; end
        default: begin mon_nm = "queues_empty"; mon_act = redir_q.size() + rd_q.size(); end
      endcase
      n_cmp++;
      if (mon_act !== mon_p.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h at %0t", mon_nm, mon_act, mon_p.exp, $time);
      end
    end
    if (rst_n && redirect_valid_o) begin
      n_cmp++;
      if (redir_q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_redirect: got pc %h expected no pulse at %0t", redirect_pc_o, $time);
      end else begin
        mon_exp = redir_q.pop_front();
        if (redirect_pc_o !== mon_exp) begin
          n_bad++;
          $display("FAIL redirect_target: got %h expected %h at %0t", redirect_pc_o, mon_exp, $time);
        end
      end
    end
    if (rst_n && c0_valid && (c0_op == 3'd0 || c0_op == 3'd3)) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL read_unexpected: got %h with empty queue at %0t", mfc0_data_o, $time);
      end else begin
        mon_exp = rd_q.pop_front();
        if (mfc0_data_o !== mon_exp) begin
          n_bad++;
          $display("FAIL read_id%0d: got %h expected %h at %0t", c0_rd_id, mfc0_data_o, mon_exp, $time);
        end
      end
    end
  end

  task automatic probe(input int k, input logic [31:0] e);
    probe_t p;
    p.kind = k;
    p.exp  = e;
    pq.push_back(p);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [4:0] id, input logic [31:0] d);
    c0_valid = 1'b1; c0_op = op; c0_rd_id = id; mtc0_data = d;
    @(posedge sys_clk); #1;
    c0_valid = 1'b0; c0_op = 3'd7; c0_rd_id = 5'd0; mtc0_data = 32'd0;
  endtask

  task automatic rd(input logic [4:0] id, input logic [31:0] e);
    rd_q.push_back(e);
    drive_op(3'd0, id, 32'd0);
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    exc_req = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
    @(posedge sys_clk); #1;
    exc_req = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
  endtask

  initial begin
    // Reset state
    @(posedge sys_clk); #1;
    probe(0, 32'd0); probe(1, 32'd0); probe(2, 32'd0); probe(3, 32'd0);
    idle(2);
    rst_n = 1'b1;
    rd(5'd9, 32'd0); rd(5'd11, 32'd0); rd(5'd12, 32'd0); rd(5'd13, 32'd0); rd(5'd14, 32'd0);
    idle(4);

    // Timer interrupt: Count from 0, Compare 5, enable IM7 + IE
    drive_op(3'd1, 5'd9, 32'd0);
    drive_op(3'd1, 5'd11, 32'd5);
    drive_op(3'd1, 5'd12, 32'h0000_8001);
    idle(7);
    probe(0, 32'd0); probe(1, 32'd0);
    rd(5'd9, 32'd4);
    probe(0, 32'd1); probe(1, 32'd1);
    redir_q.push_back(32'h0000_0180);
    idle(1);
    probe(1, 32'd0); probe(2, 32'd1);
    rd(5'd14, 32'h0000_1234);
    rd(5'd13, 32'h4000_8000);
    rd(5'd12, 32'h0000_8003);

    // Compare write clears TI; ERET back to the interrupted PC
    drive_op(3'd1, 5'd11, 32'hFFFF_0000);
    probe(0, 32'd0);
    redir_q.push_back(32'h0000_1234);
    drive_op(3'd2, 5'd0, 32'd0);

    // Exception in delay slot, then nested exception with EXL=1
    redir_q.push_back(32'h0000_0180);
    raise_exc(5'd8, 32'h0000_0400, 1'b1);
    rd(5'd14, 32'h0000_03FC);
    rd(5'd13, 32'h8000_0020);
    redir_q.push_back(32'h0000_0180);
    raise_exc(5'd10, 32'h0000_0800, 1'b0);
    rd(5'd14, 32'h0000_03FC);
    rd(5'd13, 32'h8000_0028);

    // ERET: single-cycle pulse to EPC
    redir_q.push_back(32'h0000_03FC);
    drive_op(3'd2, 5'd0, 32'd0);
    probe(2, 32'd1);
    idle(1);
    probe(2, 32'd0);
    rd(5'd12, 32'h0000_8001);

    // Exception beats a pending interrupt and a same-cycle MTC0 Status
    drive_op(3'd1, 5'd12, 32'h0000_FF01);
    hw_int_i = 5'b00001;
    exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_0500; exc_bd = 1'b0;
    c0_valid = 1'b1; c0_op = 3'd1; c0_rd_id = 5'd12; mtc0_data = 32'h0000_0000;
    probe(1, 32'd0);
    redir_q.push_back(32'h0000_0180);
    @(posedge sys_clk); #1;
    hw_int_i = 5'd0;
    exc_req = 1'b0; exc_code = 5'd0; exc_pc = 32'd0;
    c0_valid = 1'b0; c0_op = 3'd7; c0_rd_id = 5'd0;
    rd(5'd12, 32'h0000_FF03);
    rd(5'd13, 32'h0000_0010);
    rd(5'd14, 32'h0000_0500);

    // DI returns old Status; EI re-enables
    redir_q.push_back(32'h0000_0500);
    drive_op(3'd2, 5'd0, 32'd0);
    rd_q.push_back(32'h0000_FF01);
    drive_op(3'd3, 5'd0, 32'd0);
    rd(5'd12, 32'h0000_FF00);
    drive_op(3'd4, 5'd0, 32'd0);
    rd(5'd12, 32'h0000_FF01);

    // Hardware line 0 interrupt
    int_pc = 32'h0000_2000;
    hw_int_i = 5'b00001;
    probe(1, 32'd1);
    redir_q.push_back(32'h0000_0180);
    rd(5'd13, 32'h0000_0410);
    hw_int_i = 5'd0;
    probe(1, 32'd0);
    rd(5'd14, 32'h0000_2000);
    rd(5'd13, 32'h0000_0000);
    rd(5'd12, 32'h0000_FF03);

    // Write masks and unmapped ids
    drive_op(3'd1, 5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0000_0300);
    drive_op(3'd1, 5'd13, 32'h0000_0000);
    drive_op(3'd1, 5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 32'h0000_FF03);
    drive_op(3'd1, 5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 32'h0000_0000);
    rd(5'd11, 32'hFFFF_0000);

    // Reset while a redirect pulse is high clears it at once
    raise_exc(5'd2, 32'h0000_0600, 1'b0);
    rst_n = 1'b0;
    probe(2, 32'd0); probe(3, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    probe(4, 32'd0);
    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Parametrised coprocessor-0 for the pipeline.
- Adds real Status/Cause/EPC/Count/Compare registers, a Count/Compare timer, hardware-interrupt sampling and masking, and exception/ERET sequencing with a PC-redirect output.
- Sits beside the execute stage: takes decoded CP0 ops and exception requests, supplies MFC0 read data and a one-cycle redirect to the fetch stage.

Parameters:
NUM_HW_INT, 5, number of external interrupt lines (1..5), mapped to Cause.IP[2+NUM_HW_INT-1:2]
COUNT_DIV, 2, sys_clk cycles per Count increment (>=1)
EXC_VECTOR, 32'h0000_0180, redirect target for all exceptions and interrupts

Ports:
sys_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
c0_valid  in  1  a CP0 instruction is in execute this cycle
c0_op  in  3  0 MFC0, 1 MTC0, 2 ERET, 3 DI, 4 EI; others NOP
c0_rd_id  in  5  CP0 register number
mtc0_data  in  32  MTC0 write data
mfc0_data_o  out  32  read data (MFC0; old Status for DI)
hw_int_i  in  NUM_HW_INT  level-sensitive interrupt lines, already synchronous to sys_clk
exc_req  in  1  synchronous exception this cycle
exc_code  in  5  ExcCode for exc_req
exc_pc  in  32  PC of the faulting instruction
exc_bd  in  1  faulting instruction is in a branch delay slot
int_pc  in  32  PC of the instruction an interrupt would restart at
irq_take_o  out  1  comb; interrupt accepted this cycle, pipeline must flush
redirect_valid_o  out  1  registered one-cycle pulse
redirect_pc_o  out  32  registered target, valid while redirect_valid_o=1
timer_int_o  out  1  Cause.TI

Behaviour:
- Registers: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; all other ids read 0 and ignore writes.
- Status bit layout: IM[15:8], EXL[1], IE[0]; other bits read 0.
- Cause bit layout: BD[31], TI[30], IP[15:8], ExcCode[6:2].
- Reset (async, rst_n=0): all registers 0, prescaler 0, redirect_valid_o=0, redirect_pc_o=0.
- Read: mfc0_data_o is combinational from the current register value selected by c0_rd_id (pre-write, same cycle).
- MTC0 write masks:
  - Status: only IM, EXL and IE are writable.
  - Cause: only IP[1:0] (software interrupts) is writable.
  - Count and Compare: full 32 bits.
- Interrupt inputs: IP[2+k] = hw_int_i[k], resampled every cycle and not latched. IP[7] = TI OR (hw line 5 when NUM_HW_INT=5).
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments (mod 2^32) when the prescaler wraps.
  - TI sets on the cycle Count becomes equal to Compare through an increment.
  - MTC0 Compare clears TI; the write wins over a simultaneous match.
  - MTC0 Count loads the value, clears the prescaler and beats a same-cycle increment.
- int_pending = IE & ~EXL & |(IP & IM).
- Priority per cycle: exc_req > int_pending > ERET > DI/EI/MTC0. A lower-priority c0 op is suppressed (no state change).
- Exception entry (exc_req, or interrupt with ExcCode 0):
  - ExcCode is always updated.
  - If EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc, BD <= exc_bd. For interrupts use int_pc with BD=0.
  - If EXL=1: EPC and BD are unchanged.
  - EXL <= 1. Next cycle redirect_valid_o=1, redirect_pc_o=EXC_VECTOR.
- irq_take_o = int_pending & ~exc_req.
- ERET: EXL <= 0; next cycle redirect pulse with redirect_pc_o = EPC (value before any same-cycle write).
- DI: IE <= 0, and mfc0_data_o returns the pre-DI Status. EI: IE <= 1.
- Redirect latency is exactly 1 cycle. Back-to-back events give back-to-back pulses. Reset mid-pulse clears it immediately.

Test Plan:
- Reset, then MFC0 of ids 9/11/12/13/14 -> all read 0; no redirect pulses while idle.
- COUNT_DIV=2, MTC0 Compare=5, then MTC0 Status=0x0000_8001 -> Count reaches 5 after 10 cycles; TI=1 and irq_take_o=1 that cycle; EPC=int_pc; next cycle redirect to 0x180; EXL=1 so irq_take_o drops.
- exc_req with code 8, exc_pc=0x400, exc_bd=1 -> EPC=0x3FC, BD=1, ExcCode=8; redirect to 0x180. A second exc_req with EXL=1 leaves EPC at 0x3FC.
- ERET with EPC=0x3FC -> EXL=0; next cycle redirect_pc_o=0x3FC; pulse lasts exactly 1 cycle.
- Simultaneous exc_req, int_pending and MTC0 Status -> exception wins, Status unchanged except EXL=1, ExcCode=exc_code.
- DI with Status=0x0000_FF01 -> mfc0_data_o=0x0000_FF01, then Status=0x0000_FF00. MTC0 Compare during TI=1 -> TI=0 next cycle.
